// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared coefficient indices, widths and reset values for the biquad cascade
package iir_pkg;

  typedef enum logic [2:0] {
    B0 = 3'd0,
    B1 = 3'd1,
    B2 = 3'd2,
    A1 = 3'd3,
    A2 = 3'd4
  } coef_idx_e;

  localparam int N_COEF = 5;

  // Five products of DATA_W x COEF_W need three guard bits on top of the product width
  function automatic int acc_width(input int data_w, input int coef_w);
    return data_w + coef_w + 3;
  endfunction

  // Identity filter: b0 = 1.0 in Q.FRAC_W, everything else zero
  function automatic int identity_coef(input int k, input int frac_w);
    return (k == int'(B0)) ? (1 << frac_w) : 0;
  endfunction

endpackage

// File: rtl/iir_biquad.sv
// rtl/iir_biquad.sv - one Direct Form I biquad section with registered output
module iir_biquad
  import iir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] sample,
  input  logic                     sample_valid,
  input  logic                     sample_bypass,
  input  logic signed [COEF_W-1:0] b0,
  input  logic signed [COEF_W-1:0] b1,
  input  logic signed [COEF_W-1:0] b2,
  input  logic signed [COEF_W-1:0] a1,
  input  logic signed [COEF_W-1:0] a2,
  output logic signed [DATA_W-1:0] result,
  output logic                     result_valid,
  output logic                     result_bypass
);

  localparam int AW = acc_width(DATA_W, COEF_W);
  localparam int PW = DATA_W + COEF_W;
  localparam logic signed [AW-1:0] RND  = AW'(1) <<< (FRAC_W - 1);
  localparam logic signed [AW-1:0] MAXV = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] x1, x2, y1, y2;
  logic signed [DATA_W-1:0] hx1, hx2, hy1, hy2;
  logic signed [DATA_W-1:0] sat;
  logic signed [PW-1:0]     p0, p1, p2, p3, p4;
  logic signed [AW-1:0]     acc, scaled;

  // A clear in the same cycle as a sample makes that sample see zero history
  always_comb begin
    hx1 = clr ? '0 : x1;
    hx2 = clr ? '0 : x2;
    hy1 = clr ? '0 : y1;
    hy2 = clr ? '0 : y2;
    p0 = PW'(sample) * PW'(b0);
    p1 = PW'(hx1) * PW'(b1);
    p2 = PW'(hx2) * PW'(b2);
    p3 = PW'(hy1) * PW'(a1);
    p4 = PW'(hy2) * PW'(a2);
    acc = AW'(p0) + AW'(p1) + AW'(p2) - AW'(p3) - AW'(p4);
    scaled = (acc + RND) >>> FRAC_W;
    if (scaled > MAXV) begin
      sat = MAXV[DATA_W-1:0];
    end else if (scaled < MINV) begin
      sat = MINV[DATA_W-1:0];
    end else begin
      sat = scaled[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x1            <= '0;
      x2            <= '0;
      y1            <= '0;
      y2            <= '0;
      result        <= '0;
      result_valid  <= 1'b0;
      result_bypass <= 1'b0;
    end else begin
      result_valid <= sample_valid;
      if (sample_valid) begin
        result_bypass <= sample_bypass;
        result        <= sample_bypass ? sample : sat;
      end
      // Bypassed samples flow through without touching the history
      if (sample_valid && !sample_bypass) begin
        x1 <= sample;
        x2 <= hx1;
        y1 <= sat;
        y2 <= hy1;
      end else if (clr) begin
        x1 <= '0;
        x2 <= '0;
        y1 <= '0;
        y2 <= '0;
      end
    end
  end

endmodule

// File: rtl/iir_biquad_cascade.sv
// rtl/iir_biquad_cascade.sv - N_SECT cascaded biquads with a shared coefficient register file
module iir_biquad_cascade
  import iir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 14,
  parameter int N_SECT = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic signed [DATA_W-1:0]         x_in,
  input  logic                             x_valid,
  output logic signed [DATA_W-1:0]         y_out,
  output logic                             y_valid,
  input  logic                             bypass,
  input  logic                             clr,
  input  logic                             cfg_we,
  input  logic [$clog2(5*N_SECT)-1:0]      cfg_addr,
  input  logic signed [COEF_W-1:0]         cfg_data
);

  localparam int N_COEF_TOT = N_COEF * N_SECT;

  logic signed [COEF_W-1:0] coef        [N_COEF_TOT];
  logic signed [DATA_W-1:0] stage_data  [N_SECT+1];
  logic                     stage_valid [N_SECT+1];
  logic                     stage_byp   [N_SECT+1];

  // Out-of-range addresses match no entry and are dropped
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_COEF_TOT; i++) begin
      if (!rst_n) begin
        coef[i] <= COEF_W'(identity_coef(i % N_COEF, FRAC_W));
      end else if (cfg_we && (int'(cfg_addr) == i)) begin
        coef[i] <= cfg_data;
      end
    end
  end

  assign stage_data[0]  = x_in;
  assign stage_valid[0] = x_valid;
  assign stage_byp[0]   = bypass;

  for (genvar s = 0; s < N_SECT; s++) begin : g_sect
    iir_biquad #(
      .DATA_W(DATA_W),
      .COEF_W(COEF_W),
      .FRAC_W(FRAC_W)
    ) u_sect (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (clr),
      .sample       (stage_data[s]),
      .sample_valid (stage_valid[s]),
      .sample_bypass(stage_byp[s]),
      .b0           (coef[s*N_COEF + int'(B0)]),
      .b1           (coef[s*N_COEF + int'(B1)]),
      .b2           (coef[s*N_COEF + int'(B2)]),
      .a1           (coef[s*N_COEF + int'(A1)]),
      .a2           (coef[s*N_COEF + int'(A2)]),
      .result       (stage_data[s+1]),
      .result_valid (stage_valid[s+1]),
      .result_bypass(stage_byp[s+1])
    );
  end

  assign y_out   = stage_data[N_SECT];
  assign y_valid = stage_valid[N_SECT];

endmodule
